// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern engine: FSM states, step modes and bounce direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/led_pattern_engine_btn_conditioner.sv
// Button conditioning: 2-flop synchroniser, optional debounce filter (LPE_DEBOUNCE_EN),
// rising-edge detector producing the single-cycle pulse btn_p.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_p
);

  logic sync1, sync2;
  logic level, level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

`ifdef LPE_DEBOUNCE_EN
  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  logic [DCW-1:0] deb_cnt;
  logic           filt;

  // Filtered level flips only after DEB_CYCLES consecutive cycles at the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      filt    <= 1'b0;
    end else if (sync2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      filt    <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign btn_p = level & ~level_d;

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine top: start/pause FSM, programmable tick counter and pattern stepping.
// Optional button debounce is enabled by defining LPE_DEBOUNCE_EN.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W      = 16,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             button,
  input  logic [SEL_W-1:0] switch,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             running
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  state_t           state;
  logic [CNT_W-1:0] cnt, term;
  logic [LED_W-1:0] pat, pat_nxt, seed;
  logic             dir, dir_nxt;
  logic             phase, phase_nxt;
  logic             tick;
  logic             btn_p;

  btn_conditioner #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .btn_p  (btn_p)
  );

  always_comb begin
    seed = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      if (i <= 32'(switch)) seed[i] = 1'b1;
    end
  end

  // Comparing with >= lets a speed-up mid-period wrap on the very next cycle.
  assign term = CNT_W'((TICK_DIV >> speed) - 1);
  assign tick = (state == RUN) && (cnt >= term);

  always_comb begin
    pat_nxt   = pat;
    dir_nxt   = dir;
    phase_nxt = phase;
    if (state == IDLE) begin
      pat_nxt = seed;
    end else if (tick) begin
      phase_nxt = 1'b0;
      case (mode_t'(mode))
        ROT_L: pat_nxt = {pat[LED_W-2:0], pat[LED_W-1]};
        ROT_R: pat_nxt = {pat[0], pat[LED_W-1:1]};
        BOUNCE: begin
          if (pat[LED_W-1] && pat[0]) begin
            pat_nxt = pat;
          end else if (dir == DIR_L) begin
            if (pat[LED_W-1]) begin
              dir_nxt = DIR_R;
              pat_nxt = pat >> 1;
            end else begin
              pat_nxt = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              dir_nxt = DIR_L;
              pat_nxt = pat << 1;
            end else begin
              pat_nxt = pat >> 1;
            end
          end
        end
        BLINK:   phase_nxt = ~phase;
        default: pat_nxt = pat;
      endcase
    end
  end

  // The step is computed before the state transition, so a coincident btn_p freezes the stepped value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pat     <= LED_W'(1);
      dir     <= DIR_L;
      phase   <= 1'b0;
      led     <= LED_W'(1);
      running <= 1'b0;
    end else begin
      pat   <= pat_nxt;
      dir   <= dir_nxt;
      phase <= phase_nxt;
      led   <= phase_nxt ? '0 : pat_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_p) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (btn_p) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (btn_p) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed and randomized stimulus vs a behavioural model.
module tb_led_pattern_engine;

  localparam int unsigned LW   = 16;
  localparam int unsigned SW   = 3;
  localparam int unsigned TD   = 8;
  localparam int unsigned DC   = 4;
  localparam int unsigned MASK = (1 << LW) - 1;
`ifdef LPE_DEBOUNCE_EN
  localparam int unsigned LAT = DC + 3;
  localparam bit          DEB = 1'b1;
`else
  localparam int unsigned LAT = 3;
  localparam bit          DEB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          button = 1'b0;
  logic [SW-1:0] switch = '0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    speed = 2'd0;
  logic [LW-1:0] led;
  logic          running;
  logic [2:0]    switch8 = 3'd7;
  logic [1:0]    mode8 = 2'd2;
  logic [1:0]    speed8 = 2'd3;
  logic [7:0]    led8;
  logic          running8;

  led_pattern_engine #(
    .LED_W (LW), .SEL_W (SW), .TICK_DIV (TD), .DEB_CYCLES (DC)
  ) dut (
    .clk (clk), .rst_n (rst_n), .button (button), .switch (switch),
    .mode (mode), .speed (speed), .led (led), .running (running)
  );

  led_pattern_engine #(
    .LED_W (8), .SEL_W (3), .TICK_DIV (TD), .DEB_CYCLES (DC)
  ) dut8 (
    .clk (clk), .rst_n (rst_n), .button (button), .switch (switch8),
    .mode (mode8), .speed (speed8), .led (led8), .running (running8)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model: 0 idle, 1 run, 2 pause
  int          m_state;
  int          m_cnt;
  int unsigned m_pat;
  bit          m_phase;
  bit          m_dir;
  int          m_pend;
  int unsigned m_led8;

  function automatic int unsigned seed_of(int unsigned s);
    return (1 << (s + 1)) - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pat = 1; m_phase = 1'b0;
    m_dir = 1'b0; m_pend = 0; m_led8 = 1;
  endtask

  task automatic do_step();
    bit top, bot;
    top = m_pat[LW-1];
    bot = m_pat[0];
    if (mode != 2'd3) m_phase = 1'b0;
    case (mode)
      2'd0: m_pat = ((m_pat << 1) | (m_pat >> (LW - 1))) & MASK;
      2'd1: m_pat = (m_pat >> 1) | ((m_pat & 1) << (LW - 1));
      2'd2: begin
        if (top && bot) begin
          m_pat = m_pat;
        end else if (!m_dir) begin
          if (top) begin m_dir = 1'b1; m_pat = m_pat >> 1; end
          else m_pat = (m_pat << 1) & MASK;
        end else begin
          if (bot) begin m_dir = 1'b0; m_pat = (m_pat << 1) & MASK; end
          else m_pat = m_pat >> 1;
        end
      end
      default: m_phase = ~m_phase;
    endcase
  endtask

  task automatic model_edge();
    bit toggle;
    int per;
    toggle = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) toggle = 1'b1;
    end
    m_led8 = 'hFF;
    if (m_state == 0) begin
      m_pat = seed_of(int'(switch));
      m_cnt = 0;
    end else if (m_state == 1) begin
      per = int'(TD >> speed);
      if (m_cnt >= per - 1) begin
        m_cnt = 0;
        do_step();
      end else begin
        m_cnt++;
      end
    end
    if (toggle) m_state = (m_state == 1) ? 2 : 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("led", 32'(led), m_phase ? 32'd0 : m_pat);
    check("running", 32'(running), 32'(m_state == 1));
    check("led8", 32'(led8), m_led8);
    check("running8", 32'(running8), 32'(m_state == 1));
  endtask

  task automatic press(input int hold);
    button = 1'b1;
    if (!DEB || hold >= int'(DC)) m_pend = LAT;
    repeat (hold) cyc();
    button = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_led", 32'(led), 32'd1);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_led8", 32'(led8), 32'd1);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (m_cnt != c && n < 40) begin
      cyc();
      n++;
    end
    check("wait_cnt_bound", 32'(m_cnt), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    switch = 3'd3;
    repeat (2) cyc();
    #3 rst_n = 1'b1;
    repeat (100) cyc();

    // rotate left through a full revolution
    switch = 3'd0;
    cyc();
    mode = 2'd0; speed = 2'd0;
    press(6);
    repeat (16 * 8) cyc();

    // bounce from a two-bit seed
    async_reset();
    switch = 3'd1; mode = 2'd2;
    cyc();
    press(6);
    repeat (8 * 34) cyc();

    // rotate right with pause/resume mid-period and coincident with a tick
    mode = 2'd1;
    wait_cnt(1);
    press(6);
    press(6);
    repeat (20) cyc();
    wait_cnt(int'(TD) - int'(LAT));
    press(6);
    repeat (10) cyc();
    press(6);
    repeat (10) cyc();

    // blink then back to rotate while blanked
    mode = 2'd3; speed = 2'd2;
    repeat (20) cyc();
    begin
      int n;
      n = 0;
      while (!m_phase && n < 10) begin cyc(); n++; end
      check("blink_phase_bound", 32'(m_phase), 32'd1);
    end
    mode = 2'd0;
    repeat (10) cyc();

    // short glitch, then a full press
    press(3);
    press(6);
    repeat (10) cyc();

    repeat (25) begin
      mode   = 2'($urandom_range(0, 3));
      speed  = 2'($urandom_range(0, 3));
      switch = SW'($urandom_range(0, 7));
      repeat ($urandom_range(1, 30)) cyc();
      if ($urandom_range(0, 2) == 0) press(int'($urandom_range(2, 6)));
    end

    async_reset();
    repeat (20) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
